// File: rtl/read_response_bridge.sv
// Pipelined Avalon-MM read bridge: registered command path with a two-entry
// skid (output register + skid register), registered return path, and an
// outstanding-beat counter that backpressures the master at the limit.
module read_response_bridge #(
  parameter int unsigned ADDRESS_WIDTH = 48,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned BURST_WIDTH   = 3,
  parameter int unsigned PENDING_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  // Upstream (master-facing) side
  input  logic [ADDRESS_WIDTH-1:0] s_address,
  input  logic                     s_read,
  input  logic [DATA_WIDTH/8-1:0]  s_byteenable,
  input  logic [BURST_WIDTH-1:0]   s_burst,
  output logic                     s_waitrequest,
  output logic [DATA_WIDTH-1:0]    s_readdata,
  output logic                     s_readdatavalid,
  output logic [1:0]               s_response,
  // Downstream (slave-facing) side
  output logic [ADDRESS_WIDTH-1:0] m_address,
  output logic                     m_read,
  output logic [DATA_WIDTH/8-1:0]  m_byteenable,
  output logic [BURST_WIDTH-1:0]   m_burst,
  input  logic                     m_waitrequest,
  input  logic [DATA_WIDTH-1:0]    m_readdata,
  input  logic                     m_readdatavalid,
  input  logic [1:0]               m_response,
  output logic                     err_underflow
);

  localparam int unsigned Limit     = 2 ** (PENDING_WIDTH - 1);
  localparam int unsigned MaxBurst  = 2 ** (BURST_WIDTH - 1);
  localparam int unsigned Threshold = Limit - MaxBurst;

  logic                     skid_valid;
  logic [ADDRESS_WIDTH-1:0] skid_address;
  logic [DATA_WIDTH/8-1:0]  skid_byteenable;
  logic [BURST_WIDTH-1:0]   skid_burst;
  logic [PENDING_WIDTH-1:0] pending;
  logic [PENDING_WIDTH-1:0] pending_next;
  logic                     accept;
  logic                     out_free;
  logic                     underflow;

  // Backpressure depends on flops and reset only, never on m_waitrequest, so the
  // skid register absorbs the single command accepted while the output stalls.
  assign s_waitrequest = reset | skid_valid | (pending > PENDING_WIDTH'(Threshold));
  assign accept        = s_read & ~s_waitrequest;
  assign out_free      = ~m_read | ~m_waitrequest;
  assign underflow     = m_readdatavalid & (pending == '0);

  // Outstanding-beat count: add the accepted burst, retire one beat per return.
  always_comb begin
    pending_next = pending;
    if (accept) begin
      pending_next = pending_next + PENDING_WIDTH'(s_burst);
    end
    if (m_readdatavalid && !underflow) begin
      pending_next = pending_next - PENDING_WIDTH'(1);
    end
  end

  // Control state: command valids, pending counter, return valid and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_read          <= 1'b0;
      skid_valid      <= 1'b0;
      pending         <= '0;
      s_readdatavalid <= 1'b0;
      s_response      <= 2'b00;
      err_underflow   <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          m_read     <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          m_read <= accept;
        end
      end
      // accept implies the skid is empty, so it never overwrites a held entry.
      if (accept && !out_free) begin
        skid_valid <= 1'b1;
      end
      pending         <= pending_next;
      s_readdatavalid <= m_readdatavalid;
      s_response      <= m_response;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Command and read-data payload registers; intentionally not reset.
  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid) begin
        m_address    <= skid_address;
        m_byteenable <= skid_byteenable;
        m_burst      <= skid_burst;
      end else if (accept) begin
        m_address    <= s_address;
        m_byteenable <= s_byteenable;
        m_burst      <= s_burst;
      end
    end
    if (accept && !out_free) begin
      skid_address    <= s_address;
      skid_byteenable <= s_byteenable;
      skid_burst      <= s_burst;
    end
    s_readdata <= m_readdata;
  end

endmodule

// File: doc/read_response_bridge.md
# read_response_bridge

Pipelined Avalon-MM read bridge for the streaming DMA AFU's read master path. It registers read commands toward the slave through a two-entry skid buffer and registers read data and responses back toward the master. It counts outstanding read beats and backpressures the master so in-flight data never exceeds the configured limit. It is the read-side companion of the write response bridge and sits between the DMA read master and the host memory interconnect.

## Interface
- ADDRESS_WIDTH, 48, address width
- DATA_WIDTH, 512, data width; byteenable is DATA_WIDTH/8
- BURST_WIDTH, 3, 1+log2(MAX_BURST); MAX_BURST = 2^(BURST_WIDTH-1), a power of 2
- PENDING_WIDTH, 7, 1+log2(LIMIT); LIMIT = 2^(PENDING_WIDTH-1) outstanding beats; LIMIT >= MAX_BURST required

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- s_address  in  ADDRESS_WIDTH  upstream read address
- s_read  in  1  upstream read request
- s_byteenable  in  DATA_WIDTH/8  upstream byteenable
- s_burst  in  BURST_WIDTH  burst length, 1..MAX_BURST
- s_waitrequest  out  1  upstream backpressure
- s_readdata  out  DATA_WIDTH  returned data
- s_readdatavalid  out  1  returned beat valid
- s_response  out  2  Avalon response per beat
- m_address, m_read, m_byteenable, m_burst  out  (widths as s_)  downstream command
- m_waitrequest  in  1  downstream backpressure
- m_readdata  in  DATA_WIDTH; m_readdatavalid  in  1; m_response  in  2  downstream return
- err_underflow  out  1  sticky protocol-error flag

## Operation
- Accept: accept = s_read & !s_waitrequest.
- s_waitrequest = reset | skid_valid | (pending > LIMIT-MAX_BURST). It is combinational from flops and reset only, with no path from m_waitrequest.
- Output register (m_*):
  - It is free when !m_read | !m_waitrequest.
  - When free, it loads from the skid if skid_valid (and clears skid_valid). Otherwise it loads from upstream if accept. Otherwise m_read <= 0.
  - When not free, it holds all fields.
- Skid register: captures the upstream command when accept occurs while the output register is not free (sets skid_valid). It never captures when already valid.
- Ordering: commands reach m_* in acceptance order, each exactly once. No drop, no duplicate.
- pending counter (PENDING_WIDTH bits):
  - +s_burst on accept; -1 on m_readdatavalid.
  - On simultaneous events: pending + s_burst - 1.
  - Bound: it never exceeds LIMIT.
- Underflow: m_readdatavalid with pending==0 leaves pending at 0 and sets err_underflow. err_underflow is sticky and cleared only by reset.
- Return path: s_readdata, s_readdatavalid and s_response are m_* registered one cycle, unconditional. There is no return backpressure.
- s_burst==0 is illegal. It is counted as 0 beats and not checked.

## Timing
- Reset values:
  - m_read=0, skid_valid=0, pending=0, s_readdatavalid=0, s_response=2'b00, err_underflow=0.
  - s_waitrequest=1 while reset is high and 0 the first cycle after release.
  - Address, data, byteenable and burst registers are not reset.
- Command latency: accept in cycle N, m_read=1 in N+1 if the output register is free. Via the skid it is 1 cycle after the output register frees.
- s_waitrequest rises the cycle after skid capture, so at most one extra command is absorbed.
- Response latency: m_readdatavalid in N, s_readdatavalid in N+1, with data and response.
- Backpressure release: s_waitrequest falls the cycle after pending drops to LIMIT-MAX_BURST and the skid is empty.
- Reset mid-operation: held and skid commands are discarded and pending is cleared. Beats returned after reset from pre-reset reads are not filtered and set err_underflow. The slave must be reset together with the bridge.

## Test plan
- Basic burst: one read, address 0x1000, burst 4, m_waitrequest=0 -> m_read=1 with 0x1000 and burst 4 one cycle after accept. Four m_readdatavalid beats (data 0..3) -> s_readdatavalid each one cycle later with the same data; pending goes 0→4→0.
- Skid: m_waitrequest=1 for 3 cycles while the master issues reads A, B, C back-to-back.
  - Required: A held on m_*, B captured in the skid, s_waitrequest=1 the next cycle, C stalled.
  - After release, m_* presents A, B, C in order, each once.
- Limit (defaults LIMIT=64, MAX_BURST=4): 16 bursts of 4, no returns.
  - pending reaches 64 and s_waitrequest=1.
  - Returning 3 beats -> pending 61, still stalled.
  - A 4th beat -> pending 60, s_waitrequest=0 the next cycle.
- Simultaneous: pending=5, accept burst 2 in the same cycle as m_readdatavalid -> pending=6.
- Underflow: m_readdatavalid with pending=0 -> err_underflow=1 next cycle and held; pending stays 0; the beat is still forwarded.
- Reset mid-op: reset with m_read held, skid full and pending=8.
  - Next cycle: m_read=0, skid empty, pending=0, s_readdatavalid=0, s_waitrequest=1 during reset.
  - s_waitrequest=0 the first cycle after reset is released.
